hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage RV32I core. It drives the fetch/decode/execute/memory/writeback register enables and clears, and selects the execute-stage operand forwarding. It sequences a multi-cycle data-memory stall through a small FSM with a timeout watchdog. It sits beside the fetch/decode/execute register chain and is the only source of its enable and clear controls.

---
 rtl/hazard_ctrl_if.sv | 30 +++
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline register indices and memory handshake toward the
// controller, stage enables/clears and forwarding selects back to the datapath.
interface hazard_ctrl_if #(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5
);
  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                              RegWriteM, RegWriteW;
  logic [1:0]                        ResultSrcE, PCSrcE;
  logic                              MemReqM, MemReadyM;
  logic [1:0]                        ForwardAE, ForwardBE;
  logic                              en_fetch, en_decode, en_execute, en_memory, en_writeback;
  logic                              CLR_decode, CLR_execute;
  logic                              MemBusy, MemErr;

  // Datapath side.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
    output ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, en_fetch, en_decode, en_execute, en_memory, en_writeback,
    input  CLR_decode, CLR_execute, MemBusy, MemErr
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
    input  ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, en_fetch, en_decode, en_execute, en_memory, en_writeback,
    output CLR_decode, CLR_execute, MemBusy, MemErr
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard/stall controller with data-memory wait FSM and watchdog.
// Define HAZARD_PERF_CNT_EN to add the StallCycles/FlushCount performance counters.
module hazard_ctrl #(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT            = 255
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  StallCycles,
  output logic [31:0]  FlushCount
`endif
);

  typedef enum logic [1:0] {StRun, StMemWait, StResume} state_e;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       lw_stall, redirect, freeze, busy;
  logic       en_fetch, en_decode, en_execute, en_memory, en_writeback;
  logic       clr_decode, clr_execute;

  function automatic logic [1:0] fwd_sel(
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rs,
    input logic                              we_m,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_m,
    input logic                              we_w,
    input logic [REGISTER_ADDRESS_WIDTH-1:0] rd_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
    if (we_w && (rd_w != '0) && (rd_w == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign redirect = (hz.PCSrcE != 2'b00);
  assign lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    freeze  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      StRun: begin
        // Freeze in the same cycle the miss is seen so the access never leaves memory stage.
        if (hz.MemReqM && !hz.MemReadyM) begin
          freeze  = 1'b1;
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        freeze = 1'b1;
        busy   = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (hz.MemReadyM) begin
          state_d = StResume;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResume;
          err_d   = 1'b1;
        end
      end
      StResume: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      default: state_d = StRun;
    endcase

    en_fetch     = 1'b1;
    en_decode    = 1'b1;
    en_execute   = 1'b1;
    en_memory    = 1'b1;
    en_writeback = 1'b1;
    clr_decode   = 1'b0;
    clr_execute  = 1'b0;
    if (rst) begin
      clr_decode  = 1'b1;
      clr_execute = 1'b1;
    end else if (freeze) begin
      en_fetch     = 1'b0;
      en_decode    = 1'b0;
      en_execute   = 1'b0;
      en_memory    = 1'b0;
      en_writeback = 1'b0;
    end else if (redirect) begin
      clr_decode  = 1'b1;
      clr_execute = 1'b1;
    end else if (lw_stall) begin
      en_fetch    = 1'b0;
      en_decode   = 1'b0;
      clr_execute = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign hz.en_fetch     = en_fetch;
  assign hz.en_decode    = en_decode;
  assign hz.en_execute   = en_execute;
  assign hz.en_memory    = en_memory;
  assign hz.en_writeback = en_writeback;
  assign hz.CLR_decode   = clr_decode;
  assign hz.CLR_execute  = clr_execute;
  assign hz.MemBusy      = busy & ~rst;
  assign hz.MemErr       = err_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en_fetch) stall_q <= stall_q + 32'd1;
      if (redirect && (state_q != StMemWait)) flush_q <= flush_q + 32'd1;
    end
  end

  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level reference model checked every cycle
// plus directed scenarios with literal expectations.
module tb_hazard_ctrl;
  localparam int unsigned AW = 5;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REGISTER_ADDRESS_WIDTH(AW)) hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(
    .REGISTER_ADDRESS_WIDTH(AW),
    .MEM_TIMEOUT           (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hz         (hif)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles(stall_cycles),
    .FlushCount (flush_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: "waiting" counts elapsed frozen memory cycles; "resume" is the one
  // cycle after the wait during which the stale memory request is disregarded.
  bit          m_wait   = 1'b0;
  bit          m_resume = 1'b0;
  bit          m_err    = 1'b0;
  int unsigned m_wait_n = 0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] en;   // {fetch, decode, execute, memory, writeback}
    logic       cd;
    logic       ce;
    logic       busy;
    logic       err;
  } exp_t;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (hif.RegWriteM && hif.RdM != 0 && hif.RdM == rs) return 2'b10;
    if (hif.RegWriteW && hif.RdW != 0 && hif.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit   lw;
    lw     = (hif.ResultSrcE == 2'b01) && (hif.RdE != 0) &&
             ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
    e.fa   = fwd(hif.Rs1E);
    e.fb   = fwd(hif.Rs2E);
    e.busy = 1'b0;
    e.err  = m_err;
    if (rst) begin
      e.en = 5'b11111; e.cd = 1'b1; e.ce = 1'b1; e.err = 1'b0;
    end else if (m_wait) begin
      e.en = 5'b00000; e.cd = 1'b0; e.ce = 1'b0; e.busy = 1'b1;
    end else if (!m_resume && hif.MemReqM && !hif.MemReadyM) begin
      e.en = 5'b00000; e.cd = 1'b0; e.ce = 1'b0;
    end else if (hif.PCSrcE != 2'b00) begin
      e.en = 5'b11111; e.cd = 1'b1; e.ce = 1'b1;
    end else if (lw) begin
      e.en = 5'b00111; e.cd = 1'b0; e.ce = 1'b1;
    end else begin
      e.en = 5'b11111; e.cd = 1'b0; e.ce = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = expect_now();
    if (rst) begin
      m_wait   <= 1'b0;
      m_resume <= 1'b0;
      m_err    <= 1'b0;
      m_wait_n <= 0;
      m_stall  <= '0;
      m_flush  <= '0;
    end else begin
      if (!e.en[4]) m_stall <= m_stall + 1;
      if (!m_wait && hif.PCSrcE != 2'b00) m_flush <= m_flush + 1;
      if (m_wait) begin
        m_wait_n <= m_wait_n + 1;
        if (hif.MemReadyM) begin
          m_wait   <= 1'b0;
          m_resume <= 1'b1;
        end else if (m_wait_n + 1 == TO) begin
          m_wait   <= 1'b0;
          m_resume <= 1'b1;
          m_err    <= 1'b1;
        end
      end else if (m_resume) begin
        m_resume <= 1'b0;
      end else if (hif.MemReqM && !hif.MemReadyM) begin
        m_wait   <= 1'b1;
        m_wait_n <= 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = expect_now();
      chk("model_ForwardAE", hif.ForwardAE, e.fa);
      chk("model_ForwardBE", hif.ForwardBE, e.fb);
      chk("model_enables", {hif.en_fetch, hif.en_decode, hif.en_execute, hif.en_memory,
                            hif.en_writeback}, e.en);
      chk("model_CLR_decode", hif.CLR_decode, e.cd);
      chk("model_CLR_execute", hif.CLR_execute, e.ce);
      chk("model_MemBusy", hif.MemBusy, e.busy);
      chk("model_MemErr", hif.MemErr, e.err);
`ifdef HAZARD_PERF_CNT_EN
      chk("model_StallCycles", stall_cycles, m_stall);
      chk("model_FlushCount", flush_count, m_flush);
`endif
    end
  end

  task automatic idle();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0;
    hif.RdE  = '0; hif.RdM  = '0; hif.RdW  = '0;
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.ResultSrcE = 2'b00; hif.PCSrcE = 2'b00;
    hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; literal checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory never answers: TO frozen wait cycles, then the resume cycle raises MemErr.
  task automatic watchdog(input string tag);
    int busy_cnt;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      hif.MemReqM   = (i < 9);
      hif.MemReadyM = 1'b0;
      #2;
      if (hif.MemBusy) busy_cnt++;
      if (i == 9) begin
        chk({tag, "_err_rise"}, hif.MemErr, 1'b1);
        chk({tag, "_resume_busy"}, hif.MemBusy, 1'b0);
        chk({tag, "_resume_en_fetch"}, hif.en_fetch, 1'b1);
      end
    end
    chk({tag, "_wait_cycles"}, busy_cnt, TO);
    chk({tag, "_err_sticky"}, hif.MemErr, 1'b1);
  endtask

  initial begin
    int busy_cnt;
    int clr_cnt;
    idle();
    chk_en = 1'b1;

    tick(); tick();
    #2;
    chk("rst_en_fetch", hif.en_fetch, 1'b1);
    chk("rst_en_writeback", hif.en_writeback, 1'b1);
    chk("rst_CLR_decode", hif.CLR_decode, 1'b1);
    chk("rst_CLR_execute", hif.CLR_execute, 1'b1);
    chk("rst_MemBusy", hif.MemBusy, 1'b0);
    chk("rst_MemErr", hif.MemErr, 1'b0);
    tick();
    rst = 1'b0;

    // Forwarding priority and x0 exclusion.
    tick();
    hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.Rs1E = 5'd5;
    hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
    #2;
    chk("fwdA_mem_priority", hif.ForwardAE, 2'b10);
    tick();
    hif.RdM = 5'd0;
    #2;
    chk("fwdA_wb", hif.ForwardAE, 2'b01);
    tick();
    hif.Rs2E = 5'd0; hif.RdW = 5'd0;
    #2;
    chk("fwdB_x0", hif.ForwardBE, 2'b00);
    tick();
    idle();

    // Load-use stall, then the same hazard with a redirect overriding it.
    tick();
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd3; hif.Rs2D = 5'd3;
    #2;
    chk("lw_en_fetch", hif.en_fetch, 1'b0);
    chk("lw_en_decode", hif.en_decode, 1'b0);
    chk("lw_en_execute", hif.en_execute, 1'b1);
    chk("lw_CLR_execute", hif.CLR_execute, 1'b1);
    tick();
    hif.PCSrcE = 2'b01;
    #2;
    chk("lw_redirect_en_fetch", hif.en_fetch, 1'b1);
    chk("lw_redirect_CLR_decode", hif.CLR_decode, 1'b1);
    tick();
    idle();
    #2;
    chk("lw_released", hif.en_fetch, 1'b1);

    // Memory miss: ready low for 4 cycles then high; stale request held into resume.
    busy_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      hif.MemReqM   = (i < 6);
      hif.MemReadyM = (i == 4);
      #2;
      if (hif.MemBusy) busy_cnt++;
      if (i == 0) begin
        chk("miss_freeze_same_cycle", hif.en_memory, 1'b0);
      end
      if (i == 5) begin
        chk("resume_en_memory", hif.en_memory, 1'b1);
        chk("resume_MemBusy", hif.MemBusy, 1'b0);
      end
    end
    chk("miss_wait_cycles", busy_cnt, 4);
    idle();

    // Redirect held while frozen is applied only once the pipeline resumes.
    clr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hif.PCSrcE    = 2'b10;
      hif.MemReqM   = (i < 4);
      hif.MemReadyM = (i == 2);
      #2;
      if ((i < 3) && (hif.CLR_decode || hif.CLR_execute)) clr_cnt++;
      if (i == 3) begin
        chk("redir_resume_CLR_decode", hif.CLR_decode, 1'b1);
        chk("redir_resume_CLR_execute", hif.CLR_execute, 1'b1);
      end
    end
    chk("redir_no_clr_while_frozen", clr_cnt, 0);
    idle();

    watchdog("wd1");

    // Reset on the third wait cycle, with MemErr already set.
    for (int i = 0; i < 5; i++) begin
      tick();
      hif.MemReqM = (i < 4);
      rst         = (i == 3);
      #2;
      if (i == 3) begin
        chk("midrst_MemBusy", hif.MemBusy, 1'b0);
        chk("midrst_en_fetch", hif.en_fetch, 1'b1);
      end
      if (i == 4) begin
        chk("postrst_MemBusy", hif.MemBusy, 1'b0);
        chk("postrst_MemErr", hif.MemErr, 1'b0);
        chk("postrst_en_memory", hif.en_memory, 1'b1);
      end
    end
    idle();

    // A full-length watchdog after reset shows the wait counter restarted from zero.
    watchdog("wd2");

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
